// File: rtl/qs_tri_pkg.sv
// Shared definitions for the triangle FIFO producer path: word widths,
// field layout of the geometry/colour words, default budget and FSM states.
package qs_tri_pkg;

  localparam int TRI_WORD_W       = 224;
  localparam int PAIR_W           = 2 * TRI_WORD_W;
  localparam int DEFAULT_MAX_TRIS = 1024;

  typedef logic [TRI_WORD_W-1:0] tri_word_t;

  // Geometry word: {1'b0, X1, X2, Xmid, Mlong, Mtop, Mbottom, Ycurr, Ymid, Yend, Z1, MZ, NZ}
  localparam int G_X_W     = 16;
  localparam int G_M_W     = 24;
  localparam int G_Y_W     = 16;
  localparam int G_Z1_W    = 23;
  localparam int G_MZ_W    = 16;
  localparam int G_NZ_W    = 16;
  localparam int G_NZ_LSB      = 0;
  localparam int G_MZ_LSB      = G_NZ_LSB + G_NZ_W;
  localparam int G_Z1_LSB      = G_MZ_LSB + G_MZ_W;
  localparam int G_YEND_LSB    = G_Z1_LSB + G_Z1_W;
  localparam int G_YMID_LSB    = G_YEND_LSB + G_Y_W;
  localparam int G_YCURR_LSB   = G_YMID_LSB + G_Y_W;
  localparam int G_MBOTTOM_LSB = G_YCURR_LSB + G_Y_W;
  localparam int G_MTOP_LSB    = G_MBOTTOM_LSB + G_M_W;
  localparam int G_MLONG_LSB   = G_MTOP_LSB + G_M_W;
  localparam int G_XMID_LSB    = G_MLONG_LSB + G_M_W;
  localparam int G_X2_LSB      = G_XMID_LSB + G_X_W;
  localparam int G_X1_LSB      = G_X2_LSB + G_X_W;
  localparam int G_PAD_LSB     = G_X1_LSB + G_X_W;

  // Colour word: {32'h0, R1, MR, NR, G1, MG, NG, B1, MB, NB}
  localparam int C_BASE_W  = 16;
  localparam int C_SLOPE_W = 24;
  localparam int C_NB_LSB  = 0;
  localparam int C_MB_LSB  = C_NB_LSB + C_SLOPE_W;
  localparam int C_B1_LSB  = C_MB_LSB + C_SLOPE_W;
  localparam int C_NG_LSB  = C_B1_LSB + C_BASE_W;
  localparam int C_MG_LSB  = C_NG_LSB + C_SLOPE_W;
  localparam int C_G1_LSB  = C_MG_LSB + C_SLOPE_W;
  localparam int C_NR_LSB  = C_G1_LSB + C_BASE_W;
  localparam int C_MR_LSB  = C_NR_LSB + C_SLOPE_W;
  localparam int C_R1_LSB  = C_MR_LSB + C_SLOPE_W;
  localparam int C_PAD_LSB = C_R1_LSB + C_BASE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH_G = 2'd1,
    PUSH_C = 2'd2
  } wr_state_e;

endpackage

// File: rtl/tri_pair_hold.sv
// Holding register for one geometry/colour pair plus the output word select.
import qs_tri_pkg::*;

module tri_pair_hold (
  input  logic      clk100,
  input  logic      rst,
  input  logic      load,
  input  logic      selColor,
  input  tri_word_t geomIn,
  input  tri_word_t colorIn,
  output tri_word_t wordOut
);

  logic [PAIR_W-1:0] holdReg;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      holdReg <= '0;
    end else if (load) begin
      holdReg <= {geomIn, colorIn};
    end
  end

  assign wordOut = selColor ? holdReg[TRI_WORD_W-1:0] : holdReg[PAIR_W-1:TRI_WORD_W];

endmodule

// File: rtl/triangle_fifo_writer.sv
// Producer port of the triangle FIFO: pushes each triangle as an unsplittable
// geometry/colour word pair and enforces a per-frame triangle budget.
import qs_tri_pkg::*;

module triangle_fifo_writer #(
  parameter int MAX_TRIS = DEFAULT_MAX_TRIS,
  parameter int CNT_W    = 11
) (
  input  logic                  clk100,
  input  logic                  rst,
  input  logic                  nextFrame,
  input  logic                  setup_valid,
  output logic                  setup_ready,
  input  logic [TRI_WORD_W-1:0] setup_geom,
  input  logic [TRI_WORD_W-1:0] setup_color,
  output logic [TRI_WORD_W-1:0] CalcLine_TriangleFIFO_WriteData,
  output logic                  CalcLine_TriangleFIFO_push,
  input  logic                  CalcLine_TriangleFIFO_full,
  output logic [CNT_W-1:0]      frame_tri_count,
  output logic                  frame_overflow
);

  wr_state_e        state;
  logic             accept;
  logic             underBudget;
  logic [CNT_W-1:0] cntBase;

  always_comb begin
    setup_ready = (state == IDLE) || ((state == PUSH_C) && !CalcLine_TriangleFIFO_full);
    CalcLine_TriangleFIFO_push = ((state == PUSH_G) || (state == PUSH_C)) &&
                                 !CalcLine_TriangleFIFO_full;
    accept = setup_valid && setup_ready;
    // A frame boundary in the same cycle as an accept clears first, so the
    // budget check sees the fresh frame.
    cntBase     = nextFrame ? '0 : frame_tri_count;
    underBudget = cntBase < CNT_W'(MAX_TRIS);
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      frame_tri_count <= '0;
      frame_overflow  <= 1'b0;
    end else begin
      if (nextFrame) begin
        frame_tri_count <= '0;
        frame_overflow  <= 1'b0;
      end
      if (accept && underBudget) begin
        frame_tri_count <= cntBase + CNT_W'(1);
      end
      if (accept && !underBudget) begin
        frame_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept && underBudget) state <= PUSH_G;
        end
        PUSH_G: begin
          if (!CalcLine_TriangleFIFO_full) state <= PUSH_C;
        end
        PUSH_C: begin
          if (!CalcLine_TriangleFIFO_full) state <= (accept && underBudget) ? PUSH_G : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE the colour half is selected so the FIFO port shows the last colour word.
  tri_pair_hold uHold (
    .clk100   (clk100),
    .rst      (rst),
    .load     (accept),
    .selColor (state != PUSH_G),
    .geomIn   (setup_geom),
    .colorIn  (setup_color),
    .wordOut  (CalcLine_TriangleFIFO_WriteData)
  );

endmodule

// File: tb/tb_triangle_fifo_writer.sv
// Bench for triangle_fifo_writer: queue-based model checked every cycle plus
// directed scenarios with literal expectations.
module tb_triangle_fifo_writer;

  localparam int TMAX = 4;
  localparam int TCW  = 11;

  logic          clk100 = 1'b0;
  logic          rst;
  logic          nextFrame;
  logic          setup_valid;
  logic          setup_ready;
  logic [223:0]  setup_geom;
  logic [223:0]  setup_color;
  logic [223:0]  wdata;
  logic          push;
  logic          full;
  logic [TCW-1:0] cnt;
  logic          ovf;

  int tests = 0;
  int fails = 0;
  int dutPushes = 0;

  // Model state: words still owed to the FIFO, last latched colour, frame counters.
  logic [223:0] expQ[$];
  logic [223:0] mLast;
  int           mCnt;
  logic         mOvf;

  triangle_fifo_writer #(.MAX_TRIS(TMAX), .CNT_W(TCW)) dut (
    .clk100                          (clk100),
    .rst                             (rst),
    .nextFrame                       (nextFrame),
    .setup_valid                     (setup_valid),
    .setup_ready                     (setup_ready),
    .setup_geom                      (setup_geom),
    .setup_color                     (setup_color),
    .CalcLine_TriangleFIFO_WriteData (wdata),
    .CalcLine_TriangleFIFO_push      (push),
    .CalcLine_TriangleFIFO_full      (full),
    .frame_tri_count                 (cnt),
    .frame_overflow                  (ovf)
  );

  always #5 clk100 = ~clk100;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk100) begin
    logic         eReady, ePush;
    logic [223:0] eData;
    if (rst) begin
      expQ.delete();
      mLast = '0;
      mCnt  = 0;
      mOvf  = 1'b0;
      chk("rst_ready", 224'(setup_ready), 224'(1));
      chk("rst_push",  224'(push), 224'(0));
      chk("rst_data",  wdata, '0);
      chk("rst_count", 224'(cnt), 224'(0));
      chk("rst_ovf",   224'(ovf), 224'(0));
    end else begin
      eReady = (expQ.size() == 0) || (expQ.size() == 1 && !full);
      ePush  = (expQ.size() != 0) && !full;
      eData  = (expQ.size() != 0) ? expQ[0] : mLast;
      chk("m_ready", 224'(setup_ready), 224'(eReady));
      chk("m_push",  224'(push), 224'(ePush));
      chk("m_data",  wdata, eData);
      chk("m_count", 224'(cnt), 224'(mCnt));
      chk("m_ovf",   224'(ovf), 224'(mOvf));
      if (push) dutPushes++;
      if (ePush) void'(expQ.pop_front());
      if (nextFrame) begin
        mCnt = 0;
        mOvf = 1'b0;
      end
      if (setup_valid && eReady) begin
        mLast = setup_color;
        if (mCnt < TMAX) begin
          mCnt++;
          expQ.push_back(setup_geom);
          expQ.push_back(setup_color);
        end else begin
          mOvf = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  // Holds valid with the given pair until accepted; valid stays high on return.
  task automatic sendTri(input logic [223:0] g, input logic [223:0] c);
    setup_geom  = g;
    setup_color = c;
    setup_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (setup_ready) begin
        tick();
        return;
      end
      tick();
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: ready never rose, expected within 50 cycles");
  endtask

  task automatic pulseFrame();
    nextFrame = 1'b1;
    tick();
    nextFrame = 1'b0;
  endtask

  initial begin
    int p0;
    logic [223:0] ga, ca;
    rst = 1'b1; nextFrame = 1'b0; setup_valid = 1'b0; full = 1'b0;
    setup_geom = '0; setup_color = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", 224'(setup_ready), 224'(1));
    chk("reset_push",  224'(push), 224'(0));
    chk("reset_data",  wdata, '0);
    chk("reset_count", 224'(cnt), 224'(0));

    // Single triangle latency
    setup_geom = 224'h1; setup_color = 224'h2; setup_valid = 1'b1;
    tick();
    setup_valid = 1'b0;
    #1;
    chk("t1_push_g",  224'(push), 224'(1));
    chk("t1_data_g",  wdata, 224'h1);
    chk("t1_ready_g", 224'(setup_ready), 224'(0));
    tick();
    chk("t1_push_c",  224'(push), 224'(1));
    chk("t1_data_c",  wdata, 224'h2);
    chk("t1_count",   224'(cnt), 224'(1));
    tick();
    chk("t1_idle_push", 224'(push), 224'(0));
    chk("t1_idle_data", wdata, 224'h2);

    // Back-to-back triangles
    pulseFrame();
    p0 = dutPushes;
    for (int i = 0; i < 3; i++) sendTri(224'h100 + 224'(i), 224'h200 + 224'(i));
    setup_valid = 1'b0;
    repeat (4) tick();
    chk("t2_pushes", 224'(dutPushes - p0), 224'(6));
    chk("t2_count",  224'(cnt), 224'(3));

    // Back-pressure in both words
    pulseFrame();
    p0 = dutPushes;
    ga = {1'b0, {223{1'b1}}};
    ca = {32'h0, {96{2'b10}}};
    sendTri(ga, ca);
    setup_valid = 1'b0;
    full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_stall_g", wdata, ga);
      tick();
    end
    full = 1'b0;
    tick();
    full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_stall_c", wdata, ca);
      tick();
    end
    full = 1'b0;
    repeat (3) tick();
    chk("t3_pushes", 224'(dutPushes - p0), 224'(2));

    // Budget overflow
    pulseFrame();
    p0 = dutPushes;
    for (int i = 0; i < 6; i++) sendTri(224'h300 + 224'(i), 224'h400 + 224'(i));
    setup_valid = 1'b0;
    repeat (4) tick();
    chk("t4_pushes", 224'(dutPushes - p0), 224'(8));
    chk("t4_count",  224'(cnt), 224'(4));
    chk("t4_ovf",    224'(ovf), 224'(1));
    pulseFrame();
    chk("t4_clr_count", 224'(cnt), 224'(0));
    chk("t4_clr_ovf",   224'(ovf), 224'(0));

    // Frame boundary coincident with accept at full budget
    for (int i = 0; i < 4; i++) sendTri(224'h500 + 224'(i), 224'h600 + 224'(i));
    setup_valid = 1'b0;
    repeat (4) tick();
    chk("t5_full_count", 224'(cnt), 224'(4));
    setup_geom = 224'hABC; setup_color = 224'hDEF;
    setup_valid = 1'b1; nextFrame = 1'b1;
    tick();
    setup_valid = 1'b0; nextFrame = 1'b0;
    #1;
    chk("t5_count",  224'(cnt), 224'(1));
    chk("t5_push_g", 224'(push), 224'(1));
    chk("t5_data_g", wdata, 224'hABC);
    tick();
    chk("t5_data_c", wdata, 224'hDEF);
    repeat (2) tick();

    // Reset mid-pair
    sendTri(224'h777, 224'h888);
    setup_valid = 1'b0;
    tick();
    chk("t6_push_c", 224'(push), 224'(1));
    rst = 1'b1;
    #1;
    chk("t6_push_drop", 224'(push), 224'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("t6_ready", 224'(setup_ready), 224'(1));
    chk("t6_count", 224'(cnt), 224'(0));
    chk("t6_data",  wdata, '0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
